aes_subbytes_scheduler: RTL and testbench

Time-shares one 32-bit SubBytes unit (four forward and four inverse S-boxes, combinational, enc_dec select) between two requesters. The round datapath submits a 128-bit state that needs four column passes. Key expansion submits 32-bit SubWord jobs that need one pass. Sits between the round controller / key expansion and the single shared SubBytes instance.

---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_subbytes_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_aes_subbytes_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// ---------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the SubBytes scheduler: the state-job FSM encoding,
// the column index width and the S-box direction constants driven onto the
// shared unit's enc_dec select.
// ---------------------------------------------------------------------------
package aes_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_state_e;

  localparam int COL_W = 2;

  localparam logic ENC = 1'b1;
  localparam logic DEC = 1'b0;

endpackage

// File: rtl/aes_subbytes_scheduler.sv
// ---------------------------------------------------------------------------
// aes_subbytes_scheduler
// Time-shares one 32-bit combinational SubBytes unit between the round
// datapath (128-bit state, four column passes) and key expansion (32-bit
// SubWord, one pass). Key jobs take the S-box in their handshake cycle and
// preempt the running state column; after MAX_KEY_BURST key grants in a row
// during a state job, key_in_ready drops for one cycle so a column advances.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   st_in_*                state job input (valid/ready, data, enc_dec)
//   st_out_*               substituted state output (valid/ready, data)
//   key_in_*               SubWord job input (valid/ready, data)
//   key_out_*              SubWord result output (valid/ready, data)
//   sb_data_in/sb_enc_dec  drive the shared SubBytes unit
//   sb_data_out            result from the shared SubBytes unit
//   busy                   state job in progress (FSM not IDLE)
// ---------------------------------------------------------------------------
module aes_subbytes_scheduler
  import aes_sched_pkg::*;
#(
  parameter int MAX_KEY_BURST = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  input  logic [127:0] st_in_data,
  input  logic         st_in_enc_dec,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out_data,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  input  logic [31:0]  key_in_data,
  output logic         key_out_valid,
  input  logic         key_out_ready,
  output logic [31:0]  key_out_data,
  output logic [31:0]  sb_data_in,
  output logic         sb_enc_dec,
  input  logic [31:0]  sb_data_out,
  output logic         busy
);

  localparam int BURST_W = 3;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_KEY_BURST);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(3);

  st_state_e           state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [127:0]        work_q, work_d;
  logic                mode_q, mode_d;
  logic                st_out_valid_q, st_out_valid_d;
  logic                key_out_valid_q, key_out_valid_d;
  logic [31:0]         key_out_data_q, key_out_data_d;
  logic                busy_q, busy_d;

  logic force_state;
  logic key_grant;
  logic col_adv;

  // Column 0 is the most significant word of the state.
  function automatic logic [31:0] get_col(input logic [127:0] w,
                                          input logic [COL_W-1:0] c);
    case (c)
      2'd0:    get_col = w[127:96];
      2'd1:    get_col = w[95:64];
      2'd2:    get_col = w[63:32];
      default: get_col = w[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_col(input logic [127:0] w,
                                           input logic [COL_W-1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = w;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      default: r[31:0]   = v;
    endcase
    return r;
  endfunction

  // Arbitration and S-box bus mux. Kept apart from the next-state block,
  // which consumes sb_data_out, so the path out to the shared unit and back
  // is not seen as a loop through a single process.
  always_comb begin
    st_in_ready  = (state_q == ST_IDLE);
    force_state  = (state_q == ST_RUN) && (burst_cnt_q == BURST_MAX);
    key_in_ready = (!key_out_valid_q || key_out_ready) && !force_state;
    key_grant    = key_in_valid && key_in_ready;
    col_adv      = (state_q == ST_RUN) && !key_grant;

    sb_data_in = '0;
    sb_enc_dec = ENC;
    if (key_grant) begin
      // SubWord always uses the forward S-box, even while decrypting.
      sb_data_in = key_in_data;
      sb_enc_dec = ENC;
    end else if (col_adv) begin
      sb_data_in = get_col(work_q, col_q);
      sb_enc_dec = mode_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    burst_cnt_d     = burst_cnt_q;
    work_d          = work_q;
    mode_d          = mode_q;
    key_out_valid_d = key_out_valid_q;
    key_out_data_d  = key_out_data_q;

    if (key_grant) begin
      key_out_valid_d = 1'b1;
      key_out_data_d  = sb_data_out;
    end else if (key_out_ready) begin
      key_out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (st_in_valid) begin
          work_d  = st_in_data;
          mode_d  = st_in_enc_dec;
          col_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A key grant leaves col and work untouched: the column is stalled.
        if (col_adv) begin
          work_d = put_col(work_q, col_q, sb_data_out);
          col_d  = col_q + COL_W'(1);
          if (col_q == LAST_COL) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (st_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_RUN) || col_adv) begin
      burst_cnt_d = '0;
    end else if (key_grant) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end

    st_out_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      col_q           <= '0;
      burst_cnt_q     <= '0;
      work_q          <= '0;
      st_out_valid_q  <= 1'b0;
      key_out_valid_q <= 1'b0;
      key_out_data_q  <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      burst_cnt_q     <= burst_cnt_d;
      work_q          <= work_d;
      st_out_valid_q  <= st_out_valid_d;
      key_out_valid_q <= key_out_valid_d;
      key_out_data_q  <= key_out_data_d;
      busy_q          <= busy_d;
    end
  end

  // Direction is only meaningful while a job holds work_q.
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
  end

  assign st_out_valid  = st_out_valid_q;
  assign st_out_data   = work_q;
  assign key_out_valid = key_out_valid_q;
  assign key_out_data  = key_out_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes_subbytes_scheduler.sv
module tb_aes_subbytes_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_in_valid;
  logic         st_in_ready;
  logic [127:0] st_in_data;
  logic         st_in_enc_dec;
  logic         st_out_valid;
  logic         st_out_ready;
  logic [127:0] st_out_data;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [31:0]  key_in_data;
  logic         key_out_valid;
  logic         key_out_ready;
  logic [31:0]  key_out_data;
  logic [31:0]  sb_data_in;
  logic         sb_enc_dec;
  logic [31:0]  sb_data_out;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] kexp[$];
  logic [31:0] kobs[$];
  bit          hist[0:63];
  logic        sb_enc_at_grant;
  logic [31:0] sb_din_at_grant;
  logic        kv_after_grant;
  logic        accept_ok;

  always #5 clk = ~clk;

  aes_subbytes_scheduler #(.MAX_KEY_BURST(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_in_valid(st_in_valid), .st_in_ready(st_in_ready),
    .st_in_data(st_in_data), .st_in_enc_dec(st_in_enc_dec),
    .st_out_valid(st_out_valid), .st_out_ready(st_out_ready),
    .st_out_data(st_out_data),
    .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .key_in_data(key_in_data),
    .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
    .key_out_data(key_out_data),
    .sb_data_in(sb_data_in), .sb_enc_dec(sb_enc_dec),
    .sb_data_out(sb_data_out), .busy(busy)
  );

  // ---- AES S-box reference built from GF(2^8) arithmetic ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b, input logic enc);
    logic [7:0] s;
    if (enc) begin
      s = ginv(b);
      return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
    end
    s = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    return ginv(s);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic enc);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8], enc);
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic enc);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8], enc);
    return r;
  endfunction

  // Shared SubBytes unit seen by the scheduler.
  always_comb sb_data_out = sub_word(sb_data_in, sb_enc_dec);

  // ---- stimulus helpers ----
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just before an edge: records key handshakes that edge will take.
  task automatic key_track();
    if (key_out_valid && key_out_ready) kobs.push_back(key_out_data);
    if (key_in_valid && key_in_ready) kexp.push_back(sub_word(key_in_data, 1'b1));
  endtask

  // kmode: 0 no keys, 1 one key (kword) in first RUN cycle,
  //        2 keys offered every cycle, 3 random keys and random key_out_ready
  task automatic run_job(input logic [127:0] d, input logic enc, input int kmode,
                         input logic [31:0] kword, output int lat, output int grants,
                         output logic [127:0] res, output bit timeout);
    bit g;
    st_in_valid = 1'b1;
    st_in_data = d;
    st_in_enc_dec = enc;
    st_out_ready = 1'b0;
    if (kmode == 3) begin
      key_in_valid = 1'($urandom_range(0, 1));
      key_in_data = $urandom;
      key_out_ready = 1'($urandom_range(0, 1));
    end else begin
      key_in_valid = 1'b0;
      key_out_ready = 1'b1;
    end
    #1;
    accept_ok = st_in_ready;
    key_track();
    next_cycle();
    st_in_valid = 1'b0;
    lat = 0;
    grants = 0;
    timeout = 0;
    while (!st_out_valid) begin
      if (lat >= 64) begin
        timeout = 1;
        break;
      end
      if (kmode == 1 && lat == 1) kv_after_grant = key_out_valid;
      case (kmode)
        1: begin key_in_valid = (lat == 0); key_in_data = kword; end
        2: begin key_in_valid = 1'b1; key_in_data = $urandom; end
        3: begin
          key_in_valid = 1'($urandom_range(0, 1));
          key_in_data = $urandom;
          key_out_ready = 1'($urandom_range(0, 1));
        end
        default: key_in_valid = 1'b0;
      endcase
      #1;
      hist[lat] = key_in_ready;
      g = key_in_valid && key_in_ready;
      if (g) grants++;
      if (kmode == 1 && g) begin
        sb_enc_at_grant = sb_enc_dec;
        sb_din_at_grant = sb_data_in;
      end
      key_track();
      next_cycle();
      lat++;
    end
    res = st_out_data;
    key_in_valid = 1'b0;
    key_out_ready = 1'b1;
    #1;
    key_track();
    next_cycle();
  endtask

  task automatic consume_state();
    st_out_ready = 1'b1;
    #1;
    next_cycle();
    st_out_ready = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    st_in_valid = 0; st_in_data = '0; st_in_enc_dec = 1'b1; st_out_ready = 0;
    key_in_valid = 0; key_in_data = '0; key_out_ready = 0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (st_out_valid !== 1'b0) begin failures++; $display("FAIL reset_st_out_valid got=%b want=0", st_out_valid); end
    checks++; if (key_out_valid !== 1'b0) begin failures++; $display("FAIL reset_key_out_valid got=%b want=0", key_out_valid); end
    checks++; if (st_in_ready !== 1'b1) begin failures++; $display("FAIL reset_st_in_ready got=%b want=1", st_in_ready); end
    checks++; if (st_out_data !== 128'h0) begin failures++; $display("FAIL reset_st_out_data got=%h want=0", st_out_data); end
    checks++; if (key_out_data !== 32'h0) begin failures++; $display("FAIL reset_key_out_data got=%h want=0", key_out_data); end
    checks++; if (sb_data_in !== 32'h0 || sb_enc_dec !== 1'b1) begin
      failures++; $display("FAIL idle_bus got=%h/%b want=00000000/1", sb_data_in, sb_enc_dec);
    end
  endtask

  task automatic test_encrypt();
    int lat, gr; logic [127:0] res; bit to;
    run_job(128'h00112233445566778899aabbccddeeff, 1'b1, 0, 32'h0, lat, gr, res, to);
    checks++; if (accept_ok !== 1'b1) begin failures++; $display("FAIL enc_accept got=%b want=1", accept_ok); end
    checks++; if (to) begin failures++; $display("FAIL enc_timeout got=%0d want<64", lat); end
    checks++; if (lat != 4) begin failures++; $display("FAIL enc_latency got=%0d want=4 edges after accept", lat); end
    checks++; if (res !== 128'h638293c31bfc33f5c4eeacea4bc12816) begin
      failures++; $display("FAIL enc_data got=%h want=638293c31bfc33f5c4eeacea4bc12816", res);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL enc_busy_done got=%b want=1", busy); end
    consume_state();
  endtask

  task automatic test_decrypt();
    int lat, gr; logic [127:0] res; bit to;
    run_job(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0, 0, 32'h0, lat, gr, res, to);
    checks++; if (lat != 4 || to) begin failures++; $display("FAIL dec_latency got=%0d want=4", lat); end
    checks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin
      failures++; $display("FAIL dec_data got=%h want=00112233445566778899aabbccddeeff", res);
    end
    consume_state();
  endtask

  task automatic test_subword_during_decrypt();
    int lat, gr; logic [127:0] res; bit to;
    kexp.delete(); kobs.delete();
    run_job(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0, 1, 32'hcf4f3c09, lat, gr, res, to);
    checks++; if (gr != 1) begin failures++; $display("FAIL sw_grants got=%0d want=1", gr); end
    checks++; if (sb_enc_at_grant !== 1'b1 || sb_din_at_grant !== 32'hcf4f3c09) begin
      failures++; $display("FAIL sw_bus got=%h/%b want=cf4f3c09/1", sb_din_at_grant, sb_enc_at_grant);
    end
    checks++; if (kv_after_grant !== 1'b1) begin failures++; $display("FAIL sw_key_latency got=%b want=1", kv_after_grant); end
    checks++; if (kobs.size() != 1) begin failures++; $display("FAIL sw_key_count got=%0d want=1", kobs.size()); end
    else begin
      checks++; if (kobs[0] !== 32'h8a84eb01) begin failures++; $display("FAIL sw_key_data got=%h want=8a84eb01", kobs[0]); end
    end
    checks++; if (lat != 5 || to) begin failures++; $display("FAIL sw_state_latency got=%0d want=5", lat); end
    checks++; if (res !== 128'h00112233445566778899aabbccddeeff) begin
      failures++; $display("FAIL sw_state_data got=%h want=00112233445566778899aabbccddeeff", res);
    end
    consume_state();
  endtask

  task automatic test_starvation();
    int lat, gr; logic [127:0] res; bit to;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    kexp.delete(); kobs.delete();
    run_job(d, 1'b1, 2, 32'h0, lat, gr, res, to);
    checks++; if (lat != 12 || to) begin failures++; $display("FAIL starve_latency got=%0d want=12", lat); end
    checks++; if (gr != 8) begin failures++; $display("FAIL starve_grants got=%0d want=8", gr); end
    for (int i = 0; i < 12 && i < lat; i++) begin
      checks++;
      if (hist[i] !== ((i % 3) != 2)) begin
        failures++; $display("FAIL starve_key_ready cycle=%0d got=%b want=%b", i, hist[i], (i % 3) != 2);
      end
    end
    checks++; if (res !== sub_state(d, 1'b1)) begin
      failures++; $display("FAIL starve_data got=%h want=%h", res, sub_state(d, 1'b1));
    end
    checks++; if (kobs.size() != kexp.size()) begin
      failures++; $display("FAIL starve_key_count got=%0d want=%0d", kobs.size(), kexp.size());
    end
    for (int i = 0; i < kobs.size() && i < kexp.size(); i++) begin
      checks++; if (kobs[i] !== kexp[i]) begin failures++; $display("FAIL starve_key_data idx=%0d got=%h want=%h", i, kobs[i], kexp[i]); end
    end
    consume_state();
  endtask

  task automatic test_backpressure();
    int lat, gr; logic [127:0] res; bit to;
    logic [127:0] d;
    logic [31:0] w;
    d = {$urandom, $urandom, $urandom, $urandom};
    run_job(d, 1'b0, 0, 32'h0, lat, gr, res, to);
    st_in_valid = 1'b1;
    st_in_data = ~d;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (st_out_valid !== 1'b1 || st_in_ready !== 1'b0 || st_out_data !== sub_state(d, 1'b0)) begin
        failures++; $display("FAIL bp_state_hold cycle=%0d got=%b/%b/%h want=1/0/%h", i, st_out_valid, st_in_ready, st_out_data, sub_state(d, 1'b0));
      end
      next_cycle();
    end
    st_in_valid = 1'b0;
    consume_state();
    checks++; if (st_out_valid !== 1'b0 || st_in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_state_release got=%b/%b/%b want=0/1/0", st_out_valid, st_in_ready, busy);
    end
    // Key result backpressure.
    w = $urandom;
    key_in_valid = 1'b1; key_in_data = w; key_out_ready = 1'b0;
    #1;
    checks++; if (key_in_ready !== 1'b1) begin failures++; $display("FAIL bp_key_first_ready got=%b want=1", key_in_ready); end
    next_cycle();
    key_in_data = ~w;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (key_in_ready !== 1'b0 || key_out_valid !== 1'b1 || key_out_data !== sub_word(w, 1'b1)) begin
        failures++; $display("FAIL bp_key_hold cycle=%0d got=%b/%b/%h want=0/1/%h", i, key_in_ready, key_out_valid, key_out_data, sub_word(w, 1'b1));
      end
      next_cycle();
    end
    key_in_valid = 1'b0; key_out_ready = 1'b1;
    #1;
    checks++; if (key_in_ready !== 1'b1) begin failures++; $display("FAIL bp_key_ready_on_consume got=%b want=1", key_in_ready); end
    next_cycle();
    checks++; if (key_out_valid !== 1'b0) begin failures++; $display("FAIL bp_key_cleared got=%b want=0", key_out_valid); end
  endtask

  task automatic test_back_to_back_keys();
    logic [31:0] w[4];
    kexp.delete(); kobs.delete();
    key_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      key_in_valid = 1'b1; key_in_data = w[i];
      #1;
      checks++; if (key_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%b want=1", i, key_in_ready); end
      key_track();
      next_cycle();
      checks++; if (key_out_valid !== 1'b1 || key_out_data !== sub_word(w[i], 1'b1)) begin
        failures++; $display("FAIL b2b_data idx=%0d got=%b/%h want=1/%h", i, key_out_valid, key_out_data, sub_word(w[i], 1'b1));
      end
    end
    key_in_valid = 1'b0;
    #1;
    next_cycle();
  endtask

  task automatic test_random_mix();
    int lat, gr; logic [127:0] res; bit to;
    logic [127:0] d;
    logic e;
    kexp.delete(); kobs.delete();
    for (int j = 0; j < 12; j++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      run_job(d, e, 3, 32'h0, lat, gr, res, to);
      checks++; if (to || lat != 4 + gr) begin failures++; $display("FAIL rnd_latency job=%0d got=%0d want=%0d", j, lat, 4 + gr); end
      checks++; if (res !== sub_state(d, e)) begin failures++; $display("FAIL rnd_data job=%0d got=%h want=%h", j, res, sub_state(d, e)); end
      consume_state();
    end
    checks++; if (kobs.size() != kexp.size()) begin
      failures++; $display("FAIL rnd_key_count got=%0d want=%0d", kobs.size(), kexp.size());
    end
    for (int i = 0; i < kobs.size() && i < kexp.size(); i++) begin
      checks++; if (kobs[i] !== kexp[i]) begin failures++; $display("FAIL rnd_key_data idx=%0d got=%h want=%h", i, kobs[i], kexp[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    st_in_valid = 1'b1; st_in_data = {$urandom, $urandom, $urandom, $urandom}; st_in_enc_dec = 1'b1;
    key_in_valid = 1'b0; key_out_ready = 1'b1; st_out_ready = 1'b0;
    #1;
    next_cycle();
    st_in_valid = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_run_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || st_out_valid !== 1'b0 || key_out_valid !== 1'b0 || st_in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_run_reset got=%b/%b/%b/%b want=0/0/0/1", busy, st_out_valid, key_out_valid, st_in_ready);
    end
    next_cycle();
    checks++; if (busy !== 1'b0 || st_out_valid !== 1'b0 || st_out_data !== 128'h0) begin
      failures++; $display("FAIL mid_run_stays_idle got=%b/%b/%h want=0/0/0", busy, st_out_valid, st_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_subword_during_decrypt();
    test_starvation();
    test_backpressure();
    test_back_to_back_keys();
    test_random_mix();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
